alu_sequencer: RTL and testbench
================================

# alu_sequencer

Multi-cycle command sequencer that sits directly upstream of the `alu` block. It owns a 4-entry register file and accepts one command at a time over a valid/ready handshake. For arithmetic and logic commands it drives the ALU operand and control inputs, then captures the ALU result and carry back into the register file. Every command completes with a response record (data and flags) that is held until the consumer accepts it.

## Interface
Parameters:
- `N`, default 8: datapath width. Must match the width of the attached `alu`.

Ports:
- `i_clk`  in  1  clock; all state updates on the rising edge.
- `i_rst`  in  1  reset; asynchronous, active-high.
- `i_cmd_valid`  in  1  command present.
- `o_cmd_ready`  out  1  sequencer can accept a command; equals (state == IDLE).
- `i_cmd_op`  in  3  opcode:
  - 000 ADD, 001 SUB, 010 AND, 011 OR
  - 100 LDI
  - 101–111 illegal
- `i_cmd_rd`  in  2  destination register index.
- `i_cmd_ra`  in  2  operand A register index.
- `i_cmd_rb`  in  2  operand B register index.
- `i_cmd_imm`  in  N  immediate value, used by LDI only.
- `o_alu_a`  out  N  to `alu.i_a`; driven from operand register A.
- `o_alu_b`  out  N  to `alu.i_b`; driven from operand register B.
- `o_alu_ctrl`  out  2  to `alu.i_alu_ctrl`; driven from the latched opcode bits [1:0].
- `i_alu_result`  in  N  from `alu.o_result`.
- `i_alu_carry`  in  1  from `alu.o_carry_out`.
- `o_rsp_valid`  out  1  response present.
- `i_rsp_ready`  in  1  consumer accepts the response.
- `o_rsp_data`  out  N  result value.
- `o_rsp_carry`  out  1  carry flag.
- `o_rsp_zero`  out  1  high when `o_rsp_data` == 0.
- `o_rsp_err`  out  1  high when the command used an illegal opcode.

## Operation
States: IDLE, EXEC, RESP. Reset state is IDLE.

- **IDLE**
  - A command is accepted on `i_cmd_valid & o_cmd_ready` at a clock edge.
  - On acceptance, latch opcode and rd, and copy regs[ra] and regs[rb] into the operand registers.
  - ALU op (000–011): go to EXEC.
  - LDI: write regs[rd] <= imm. Response data = imm, carry 0, err 0. Go to RESP; EXEC is skipped.
  - Illegal op: no register write. Response data 0, carry 0, zero 1, err 1. Go to RESP.
- **EXEC** (exactly one cycle)
  - The ALU evaluates combinationally from the operand registers.
  - At the end of the cycle, write regs[rd] <= `i_alu_result` and capture the response registers. Go to RESP.
  - Carry flag for ADD and SUB is taken verbatim from `i_alu_carry`; for SUB it means "no borrow".
  - Carry flag for AND and OR is forced to 0; `i_alu_carry` is ignored.
- **RESP**
  - `o_rsp_valid` = 1. All response fields are held stable while `i_rsp_ready` = 0.
  - On `o_rsp_valid & i_rsp_ready`, go to IDLE.
- Zero flag is computed from the captured response data, not from live ALU output.
- Only one command is ever in flight, so there are no read/write hazards. A command issued after a write reads the new value.
- Operands may alias: ra == rb == rd is legal. Reads happen at acceptance and the write happens at EXEC end.
- Arithmetic is modulo 2^N. The register file has no carry-in path.

## Timing
- Reset (asynchronous, acts immediately):
  - state = IDLE
  - all 4 registers = 0
  - operand registers = 0, latched opcode = 000, so `o_alu_a` = `o_alu_b` = 0 and `o_alu_ctrl` = 00
  - `o_rsp_valid` = 0 and all response fields = 0
  - `o_cmd_ready` = 1 during and after reset.
- ALU op latency, acceptance edge to `o_rsp_valid` high:
  - 2 cycles: acceptance edge, then EXEC, then RESP visible after the second edge.
- LDI and illegal op latency: 1 cycle.
- Maximum throughput:
  - ALU ops: one per 3 cycles.
  - LDI and illegal ops: one per 2 cycles.
  - Both assume `i_rsp_ready` held high.
- `o_cmd_ready` is 0 in EXEC and RESP. A `i_cmd_valid` pulse during those states is ignored and not queued.
- A response accepted in the same cycle that a command is presented does not accept the command. The new command is accepted one cycle later, in IDLE.
- Reset mid-EXEC or mid-RESP:
  - the in-flight command is discarded, with no register write after reset;
  - the pending response is dropped.

## Test plan
1. **LDI and ADD.** Issue LDI r1=BD, LDI r2=A5, then ADD rd=r3, ra=r1, rb=r2.
   - ADD response: data 62, carry 1, zero 0, err 0, 2 cycles after acceptance.
   - During EXEC: `o_alu_a`=BD, `o_alu_b`=A5, `o_alu_ctrl`=00.
2. **SUB, AND, OR.** Using r1=BD and r2=A5:
   - SUB r0=r1-r2: data 18, carry 1.
   - AND r0: data A5, carry 0.
   - OR r0: data BD, carry 0.
   - SUB r0=r1-r1: data 00, zero 1, carry 1.
3. **Backpressure.** Hold `i_rsp_ready`=0 for 5 cycles after the ADD response appears.
   - `o_rsp_valid` and the data stay constant, `o_cmd_ready` stays 0, and a command pulsed meanwhile is ignored.
   - After ready rises: IDLE next cycle.
4. **Illegal opcode.** Issue op=110 with rd=r1.
   - Response err 1, data 0, zero 1.
   - A following ADD r3=r1+r1 shows r1 unchanged (BD+BD=7A, carry 1).
5. **Reset mid-EXEC.** Assert `i_rst` during EXEC of ADD r3.
   - All outputs return to their reset values at once.
   - After release, ADD r3=r3+r3 returns data 00, zero 1.
6. **Aliasing.** LDI r2=81, then ADD r2=r2+r2.
   - Response: data 02, carry 1.
   - A following ADD r0=r2+r0 (r0=0) returns 02.

Source files
------------

// File: rtl/alu_sequencer.sv
// Command sequencer in front of the alu block: a 4-entry register file, a one-command-at-a-time
// valid/ready front end, and a held response record with data, carry, zero and error flags.
module alu_sequencer #(
    parameter int N = 8
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_cmd_valid,
    output logic         o_cmd_ready,
    input  logic [2:0]   i_cmd_op,
    input  logic [1:0]   i_cmd_rd,
    input  logic [1:0]   i_cmd_ra,
    input  logic [1:0]   i_cmd_rb,
    input  logic [N-1:0] i_cmd_imm,
    output logic [N-1:0] o_alu_a,
    output logic [N-1:0] o_alu_b,
    output logic [1:0]   o_alu_ctrl,
    input  logic [N-1:0] i_alu_result,
    input  logic         i_alu_carry,
    output logic         o_rsp_valid,
    input  logic         i_rsp_ready,
    output logic [N-1:0] o_rsp_data,
    output logic         o_rsp_carry,
    output logic         o_rsp_zero,
    output logic         o_rsp_err
);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_LDI = 3'b100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [N-1:0] regs_q [4];

    logic [2:0]   op_p1;
    logic [1:0]   rd_p1;
    logic [N-1:0] opa_p1;
    logic [N-1:0] opb_p1;

    logic [N-1:0] rsp_data_p2;
    logic         rsp_carry_p2;
    logic         rsp_zero_p2;
    logic         rsp_err_p2;

    logic         cmd_accept;
    logic         cmd_is_alu;
    logic         cmd_is_ldi;
    logic         exec_done;

    function automatic logic zero_flag(input logic [N-1:0] d);
        return (d == '0);
    endfunction

    // Only ADD and SUB produce a meaningful carry; SUB carry is the ALU's no-borrow flag.
    function automatic logic carry_sel(input logic [2:0] op, input logic carry);
        return ((op == OP_ADD) || (op == OP_SUB)) ? carry : 1'b0;
    endfunction

    assign cmd_is_alu = (i_cmd_op == OP_ADD) || (i_cmd_op == OP_SUB) ||
                        (i_cmd_op == OP_AND) || (i_cmd_op == OP_OR);
    assign cmd_is_ldi = (i_cmd_op == OP_LDI);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        o_cmd_ready = 1'b0;
        o_rsp_valid = 1'b0;
        cmd_accept  = 1'b0;
        exec_done   = 1'b0;
        case (state_q)
            IDLE: begin
                o_cmd_ready = 1'b1;
                if (i_cmd_valid) begin
                    cmd_accept = 1'b1;
                    state_d    = cmd_is_alu ? EXEC : RESP;
                end
            end
            EXEC: begin
                exec_done = 1'b1;
                state_d   = RESP;
            end
            RESP: begin
                o_rsp_valid = 1'b1;
                if (i_rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Stage p1: command acceptance latches opcode, destination and both operand reads.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            op_p1  <= OP_ADD;
            rd_p1  <= 2'd0;
            opa_p1 <= '0;
            opb_p1 <= '0;
        end else if (cmd_accept) begin
            op_p1  <= i_cmd_op;
            rd_p1  <= i_cmd_rd;
            opa_p1 <= regs_q[i_cmd_ra];
            opb_p1 <= regs_q[i_cmd_rb];
        end
    end

    // Register file: LDI writes at acceptance, ALU ops write at the end of EXEC.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < 4; i++) begin
                regs_q[i] <= '0;
            end
        end else if (cmd_accept && cmd_is_ldi) begin
            regs_q[i_cmd_rd] <= i_cmd_imm;
        end else if (exec_done) begin
            regs_q[rd_p1] <= i_alu_result;
        end
    end

    // Stage p2: response record, loaded once per command and held through RESP.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rsp_data_p2  <= '0;
            rsp_carry_p2 <= 1'b0;
            rsp_zero_p2  <= 1'b0;
            rsp_err_p2   <= 1'b0;
        end else if (cmd_accept && cmd_is_ldi) begin
            rsp_data_p2  <= i_cmd_imm;
            rsp_carry_p2 <= 1'b0;
            rsp_zero_p2  <= zero_flag(i_cmd_imm);
            rsp_err_p2   <= 1'b0;
        end else if (cmd_accept && !cmd_is_alu) begin
            rsp_data_p2  <= '0;
            rsp_carry_p2 <= 1'b0;
            rsp_zero_p2  <= 1'b1;
            rsp_err_p2   <= 1'b1;
        end else if (exec_done) begin
            rsp_data_p2  <= i_alu_result;
            rsp_carry_p2 <= carry_sel(op_p1, i_alu_carry);
            rsp_zero_p2  <= zero_flag(i_alu_result);
            rsp_err_p2   <= 1'b0;
        end
    end

    assign o_alu_a     = opa_p1;
    assign o_alu_b     = opb_p1;
    assign o_alu_ctrl  = op_p1[1:0];
    assign o_rsp_data  = rsp_data_p2;
    assign o_rsp_carry = rsp_carry_p2;
    assign o_rsp_zero  = rsp_zero_p2;
    assign o_rsp_err   = rsp_err_p2;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural ALU attached to its operand/control outputs.
module tb_alu_sequencer;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic [2:0]   cmd_op = 3'b000;
    logic [1:0]   cmd_rd = 2'd0;
    logic [1:0]   cmd_ra = 2'd0;
    logic [1:0]   cmd_rb = 2'd0;
    logic [N-1:0] cmd_imm = '0;
    logic [N-1:0] alu_a;
    logic [N-1:0] alu_b;
    logic [1:0]   alu_ctrl;
    logic [N-1:0] alu_result;
    logic         alu_carry;
    logic         rsp_valid;
    logic         rsp_ready = 1'b0;
    logic [N-1:0] rsp_data;
    logic         rsp_carry;
    logic         rsp_zero;
    logic         rsp_err;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    // Reference ALU; logic ops drive carry high so a leaking carry is visible.
    logic [N:0] alu_full;
    always_comb begin
        alu_full = '0;
        case (alu_ctrl)
            2'b00: alu_full = {1'b0, alu_a} + {1'b0, alu_b};
            2'b01: alu_full = {(alu_a >= alu_b), alu_a - alu_b};
            2'b10: alu_full = {1'b1, alu_a & alu_b};
            default: alu_full = {1'b1, alu_a | alu_b};
        endcase
    end
    assign alu_result = alu_full[N-1:0];
    assign alu_carry  = alu_full[N];

    alu_sequencer #(.N(N)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_cmd_valid  (cmd_valid),
        .o_cmd_ready  (cmd_ready),
        .i_cmd_op     (cmd_op),
        .i_cmd_rd     (cmd_rd),
        .i_cmd_ra     (cmd_ra),
        .i_cmd_rb     (cmd_rb),
        .i_cmd_imm    (cmd_imm),
        .o_alu_a      (alu_a),
        .o_alu_b      (alu_b),
        .o_alu_ctrl   (alu_ctrl),
        .i_alu_result (alu_result),
        .i_alu_carry  (alu_carry),
        .o_rsp_valid  (rsp_valid),
        .i_rsp_ready  (rsp_ready),
        .o_rsp_data   (rsp_data),
        .o_rsp_carry  (rsp_carry),
        .o_rsp_zero   (rsp_zero),
        .o_rsp_err    (rsp_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] ra,
                           input logic [1:0] rb, input logic [N-1:0] imm);
        cmd_op    = op;
        cmd_rd    = rd;
        cmd_ra    = ra;
        cmd_rb    = rb;
        cmd_imm   = imm;
        cmd_valid = 1'b1;
    endtask

    task automatic issue(input string tag, input logic [2:0] op, input logic [1:0] rd,
                         input logic [1:0] ra, input logic [1:0] rb, input logic [N-1:0] imm);
        present(op, rd, ra, rb, imm);
        chk({tag, "_ready"}, 32'(cmd_ready), 32'd1);
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic expect_rsp(input string tag, input logic [N-1:0] d, input logic c,
                              input logic z, input logic e);
        chk({tag, "_valid"}, 32'(rsp_valid), 32'd1);
        chk({tag, "_data"},  32'(rsp_data),  32'(d));
        chk({tag, "_carry"}, 32'(rsp_carry), 32'(c));
        chk({tag, "_zero"},  32'(rsp_zero),  32'(z));
        chk({tag, "_err"},   32'(rsp_err),   32'(e));
    endtask

    task automatic take_rsp(input string tag);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk({tag, "_idle"}, {30'd0, cmd_ready, rsp_valid}, 32'b10);
    endtask

    task automatic ldi(input string tag, input logic [1:0] rd, input logic [N-1:0] imm);
        issue(tag, 3'b100, rd, 2'd0, 2'd0, imm);
        expect_rsp(tag, imm, 1'b0, (imm == '0), 1'b0);
        take_rsp(tag);
    endtask

    task automatic alu_op(input string tag, input logic [2:0] op, input logic [1:0] rd,
                          input logic [1:0] ra, input logic [1:0] rb,
                          input logic [N-1:0] d, input logic c, input logic z);
        issue(tag, op, rd, ra, rb, '0);
        chk({tag, "_exec"}, {30'd0, cmd_ready, rsp_valid}, 32'b00);
        step();
        expect_rsp(tag, d, c, z, 1'b0);
        take_rsp(tag);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ready"}, 32'(cmd_ready), 32'd1);
        chk({tag, "_alu"},   {14'd0, alu_ctrl, alu_a, alu_b}, 32'd0);
        chk({tag, "_rsp"},   {20'd0, rsp_valid, rsp_carry, rsp_zero, rsp_err, rsp_data}, 32'd0);
    endtask

    initial begin
        // Reset values, observed while reset is held.
        rst = 1'b1;
        #2;
        chk_reset_outputs("rst_hold");
        step();
        step();
        rst = 1'b0;
        step();
        chk_reset_outputs("rst_release");

        // LDI and ADD, with ALU drive checked during EXEC.
        ldi("ldi_r1", 2'd1, 8'hBD);
        ldi("ldi_r2", 2'd2, 8'hA5);
        issue("add_r3", 3'b000, 2'd3, 2'd1, 2'd2, '0);
        chk("add_exec_a",    32'(alu_a), 32'hBD);
        chk("add_exec_b",    32'(alu_b), 32'hA5);
        chk("add_exec_ctrl", 32'(alu_ctrl), 32'd0);
        chk("add_exec_hs",   {30'd0, cmd_ready, rsp_valid}, 32'b00);
        step();
        expect_rsp("add_r3", 8'h62, 1'b1, 1'b0, 1'b0);

        // Backpressure: response held, ready low, a stray LDI r0=FF is ignored.
        for (int i = 0; i < 5; i++) begin
            if (i == 2) present(3'b100, 2'd0, 2'd0, 2'd0, 8'hFF);
            step();
            cmd_valid = 1'b0;
            chk("bp_hold", {22'd0, cmd_ready, rsp_valid, rsp_data}, {24'b01, 8'h62});
        end
        // Command presented in the response-accept cycle is taken one cycle later.
        present(3'b000, 2'd0, 2'd0, 2'd0, '0);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk("bp_idle", {30'd0, cmd_ready, rsp_valid}, 32'b10);
        step();
        cmd_valid = 1'b0;
        chk("late_accept_exec", {30'd0, cmd_ready, rsp_valid}, 32'b00);
        step();
        expect_rsp("add_r0_r0", 8'h00, 1'b0, 1'b1, 1'b0);
        take_rsp("add_r0_r0");

        // SUB, AND, OR.
        alu_op("sub_r1_r2", 3'b001, 2'd0, 2'd1, 2'd2, 8'h18, 1'b1, 1'b0);
        alu_op("and_r1_r2", 3'b010, 2'd0, 2'd1, 2'd2, 8'hA5, 1'b0, 1'b0);
        alu_op("or_r1_r2",  3'b011, 2'd0, 2'd1, 2'd2, 8'hBD, 1'b0, 1'b0);
        alu_op("sub_r1_r1", 3'b001, 2'd0, 2'd1, 2'd1, 8'h00, 1'b1, 1'b1);
        alu_op("sub_r2_r1", 3'b001, 2'd0, 2'd2, 2'd1, 8'hE8, 1'b0, 1'b0);

        // Illegal opcode leaves r1 untouched.
        issue("illegal", 3'b110, 2'd1, 2'd2, 2'd2, 8'h33);
        expect_rsp("illegal", 8'h00, 1'b0, 1'b1, 1'b1);
        take_rsp("illegal");
        alu_op("add_r1_r1", 3'b000, 2'd3, 2'd1, 2'd1, 8'h7A, 1'b1, 1'b0);

        // Asynchronous reset in the middle of EXEC.
        issue("add_pre_rst", 3'b000, 2'd3, 2'd1, 2'd2, '0);
        chk("pre_rst_exec_a", 32'(alu_a), 32'hBD);
        #1;
        rst = 1'b1;
        #1;
        chk_reset_outputs("rst_exec");
        step();
        rst = 1'b0;
        step();
        chk_reset_outputs("rst_exec_after");
        alu_op("add_r3_r3", 3'b000, 2'd3, 2'd3, 2'd3, 8'h00, 1'b0, 1'b1);

        // Aliasing ra == rb == rd.
        ldi("ldi_r2_81", 2'd2, 8'h81);
        alu_op("alias_r2", 3'b000, 2'd2, 2'd2, 2'd2, 8'h02, 1'b1, 1'b0);
        alu_op("add_r0_r2", 3'b000, 2'd0, 2'd2, 2'd0, 8'h02, 1'b0, 1'b0);
        ldi("ldi_zero", 2'd1, 8'h00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
